// File: rtl/fifo_serializer_pkg.sv
// Shared types and constants for the FIFO word-to-beat serializer.
package fifo_serializer_pkg;

  localparam int unsigned WORD_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } ser_state_e;

endpackage

// File: rtl/fifo_byte_serializer.sv
// Drains the word FIFO one word at a time and emits each word as
// DATA_WIDTH/OUT_WIDTH beats on a valid/ready stream.
module fifo_byte_serializer
  import fifo_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        fifo_r_ena,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic [WORD_COUNT_WIDTH-1:0] word_count
);

  localparam int unsigned NBEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned BEAT_W = (NBEATS > 2) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  generate
    if (((DATA_WIDTH % OUT_WIDTH) != 0) || (NBEATS < 2)) begin : g_bad_params
      $error("fifo_byte_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
    end
  endgenerate

  ser_state_e            state, state_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_shifted;
  logic [BEAT_W-1:0]     beat;
  logic                  pop_req;
  logic                  load;
  logic                  shift;
  logic                  word_done;

  // Beat presented on the stream side and the register after it leaves.
  generate
    if (MSB_FIRST) begin : g_msb
      assign out_data      = shreg[DATA_WIDTH-1 -: OUT_WIDTH];
      assign shreg_shifted = {shreg[DATA_WIDTH-OUT_WIDTH-1:0], OUT_WIDTH'(0)};
    end else begin : g_lsb
      assign out_data      = shreg[OUT_WIDTH-1:0];
      assign shreg_shifted = {OUT_WIDTH'(0), shreg[DATA_WIDTH-1:OUT_WIDTH]};
    end
  endgenerate

  assign out_valid  = (state == SEND);
  assign out_last   = (state == SEND) && (beat == LAST_BEAT);
  assign busy       = (state != IDLE);
  // Read strobe is never issued while reset is held, even from an undefined state.
  assign fifo_r_ena = pop_req & ~reset;

  // State register, shift register, beat and word counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      beat       <= '0;
      word_count <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        shreg <= fifo_data;
        beat  <= '0;
      end else if (shift) begin
        shreg <= shreg_shifted;
        beat  <= beat + BEAT_W'(1);
      end
      if (word_done) begin
        word_count <= word_count + WORD_COUNT_WIDTH'(1);
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    pop_req    = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    word_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          pop_req    = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        load       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (out_ready) begin
          shift = 1'b1;
          if (beat == LAST_BEAT) begin
            word_done = 1'b1;
            // Chain straight into the next fetch to leave a single bubble.
            if (enable && !fifo_empty) begin
              pop_req    = 1'b1;
              state_next = FETCH;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one FIFO model and stimulus.
module tb_fifo_byte_serializer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        out_ready;

  logic        m_rena, l_rena;
  logic [7:0]  m_data, l_data;
  logic        m_valid, l_valid;
  logic        m_last, l_last;
  logic        m_busy, l_busy;
  logic [15:0] m_wc, l_wc;

  beat_t       exp_m[$];
  beat_t       exp_l[$];
  logic [31:0] fifo_q[$];
  int          rena_cyc[$];
  int          acc_cyc[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          m_rena_n = 0;
  int          l_rena_n = 0;

  always #5 clk = ~clk;

  fifo_byte_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_r_ena(m_rena), .out_data(m_data),
    .out_valid(m_valid), .out_ready(out_ready), .out_last(m_last),
    .busy(m_busy), .word_count(m_wc)
  );

  fifo_byte_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_r_ena(l_rena), .out_data(l_data),
    .out_valid(l_valid), .out_ready(out_ready), .out_last(l_last),
    .busy(l_busy), .word_count(l_wc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Registered-read FIFO model driven by the MSB instance's strobe.
  always @(posedge clk) begin
    cyc++;
    if (m_rena && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
  end

  // Monitor: log strobes and pop/compare every accepted beat.
  always @(negedge clk) begin
    beat_t e;
    if (m_rena) begin
      rena_cyc.push_back(cyc);
      m_rena_n++;
    end
    if (l_rena) l_rena_n++;
    if (!reset && m_valid && out_ready) begin
      acc_cyc.push_back(cyc);
      if (exp_m.size() == 0) begin
        chk("m_unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_m.pop_front();
        chk("m_beat_data", 32'(m_data), 32'(e.data));
        chk("m_beat_last", 32'(m_last), 32'(e.last));
      end
    end
    if (!reset && l_valid && out_ready) begin
      if (exp_l.size() == 0) begin
        chk("l_unexpected_beat", 32'(l_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_l.pop_front();
        chk("l_beat_data", 32'(l_data), 32'(e.data));
        chk("l_beat_last", 32'(l_last), 32'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_m.push_back('{data: w[31-8*i -: 8], last: (i == 3)});
      exp_l.push_back('{data: w[8*i +: 8],    last: (i == 3)});
    end
  endtask

  task automatic wait_wc(input int target, input int budget, input string name);
    int n = 0;
    while (m_wc != 16'(target) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(m_wc), 32'(target));
    chk({name, "_l"}, 32'(l_wc), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1; fifo_empty = 1'b1; fifo_data = '0;

    // Reset held with a word waiting and enable high.
    push(32'hA1B2C3D4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rena",  32'(m_rena),  0);
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_data",  32'(m_data),  0);
      chk("rst_last",  32'(m_last),  0);
      chk("rst_busy",  32'(m_busy),  0);
      chk("rst_wc",    32'(m_wc),    0);
    end
    reset = 1'b0;
    #1;
    chk("rel_busy_idle", 32'(m_busy), 0);
    chk("rel_rena",      32'(m_rena), 1);
    chk("rel_rena_l",    32'(l_rena), 1);

    // Single word, full throughput.
    wait_wc(1, 20, "single_wc");
    chk("single_pulses", 32'(rena_cyc.size()), 1);
    chk("single_beats",  32'(acc_cyc.size()), 4);
    if (rena_cyc.size() == 1 && acc_cyc.size() == 4) begin
      chk("single_latency", 32'(acc_cyc[0]), 32'(rena_cyc[0] + 2));
      for (int i = 1; i < 4; i++) chk("single_consec", 32'(acc_cyc[i]), 32'(acc_cyc[0] + i));
    end
    tick();
    chk("single_idle", 32'(m_busy), 0);
    rena_cyc.delete(); acc_cyc.delete();

    // Backpressure while B2 is presented.
    push(32'hA1B2C3D4);
    n = 0;
    while (!(m_valid && m_data == 8'hB2) && n < 20) begin tick(); n++; end
    chk("bp_reach_b2", 32'(m_data), 32'hB2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", 32'(m_valid), 1);
      chk("bp_hold_data",  32'(m_data),  32'hB2);
      chk("bp_hold_last",  32'(m_last),  0);
      chk("bp_hold_l",     32'(l_data),  32'hC3);
    end
    out_ready = 1'b1;
    wait_wc(2, 20, "bp_wc");
    if (acc_cyc.size() == 4) begin
      chk("bp_stall_gap", 32'(acc_cyc[1] - acc_cyc[0]), 4);
      chk("bp_resume",    32'(acc_cyc[2] - acc_cyc[1]), 1);
    end else chk("bp_beats", 32'(acc_cyc.size()), 4);
    rena_cyc.delete(); acc_cyc.delete();

    // Back-to-back words.
    tick();
    push(32'h11223344);
    push(32'h55667788);
    wait_wc(4, 40, "b2b_wc");
    chk("b2b_pulses", 32'(rena_cyc.size()), 2);
    chk("b2b_beats",  32'(acc_cyc.size()), 8);
    if (rena_cyc.size() == 2 && acc_cyc.size() == 8) begin
      chk("b2b_rena_on_last", 32'(rena_cyc[1]), 32'(acc_cyc[3]));
      chk("b2b_one_bubble",   32'(acc_cyc[4] - acc_cyc[3]), 2);
    end
    rena_cyc.delete(); acc_cyc.delete();

    // Enable drops after the first beat; word completes, no further pops.
    push(32'hCAFEF00D);
    push(32'h01020304);
    n = 0;
    while (acc_cyc.size() < 1 && n < 20) begin tick(); n++; end
    enable = 1'b0;
    n = 0;
    while (m_busy && n < 30) begin tick(); n++; end
    tick(); tick();
    chk("en_busy",    32'(m_busy), 0);
    chk("en_beats",   32'(acc_cyc.size()), 4);
    chk("en_pulses",  32'(rena_cyc.size()), 1);
    chk("en_wc",      32'(m_wc), 5);
    chk("en_fifo_left", 32'(fifo_q.size()), 1);
    enable = 1'b1;
    wait_wc(6, 30, "en_resume_wc");
    rena_cyc.delete(); acc_cyc.delete();

    // Reset after beat 2: partial word dropped, no re-read.
    push(32'h0BADBEEF);
    n = 0;
    while (acc_cyc.size() < 2 && n < 20) begin tick(); n++; end
    reset = 1'b1;
    exp_m.delete(); exp_l.delete();
    #1;
    chk("mid_rst_rena", 32'(m_rena), 0);
    tick();
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_wc",    32'(m_wc),    0);
    chk("mid_rst_busy",  32'(m_busy),  0);
    chk("mid_rst_data",  32'(m_data),  0);
    push(32'h12345678);
    #1;
    chk("mid_rst_rena_full", 32'(m_rena), 0);
    tick();
    chk("mid_rst_rena_hold", 32'(m_rena), 0);
    reset = 1'b0;
    #1;
    chk("mid_rel_rena", 32'(m_rena), 1);
    wait_wc(1, 20, "mid_after_wc");
    chk("mid_pulses", 32'(rena_cyc.size()), 2);

    tick(); tick();
    chk("end_exp_m_empty", 32'(exp_m.size()), 0);
    chk("end_exp_l_empty", 32'(exp_l.size()), 0);
    chk("end_pops_m", 32'(m_rena_n), 8);
    chk("end_pops_l", 32'(l_rena_n), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_byte_serializer.md
# fifo_byte_serializer

Downstream drain stage for the team's word FIFO. It pops one DATA_WIDTH-bit word at a time through the FIFO read port and emits the word as DATA_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream, which feeds byte-oriented consumers such as a UART TX or a byte bus. The block owns the FIFO read enable and stalls on both FIFO-empty and downstream backpressure.

## Interface
- DATA_WIDTH, 32: FIFO word width. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8: output beat width.
- MSB_FIRST, 1: 1 sends the most-significant slice first; 0 sends the least-significant slice first.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  permits new FIFO pops. Does not abort a word in flight.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO registered read data, valid the cycle after fifo_r_ena.
- fifo_r_ena  out  1  FIFO read strobe, one cycle per word.
- out_data  out  OUT_WIDTH  current beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  final beat of the current word.
- busy  out  1  state != IDLE.
- word_count  out  16  count of fully sent words; wraps 0xFFFF -> 0.

## Operation
- NBEATS = DATA_WIDTH/OUT_WIDTH. The beat counter is clog2(NBEATS) bits wide, minimum 1.
- The FSM has states IDLE, FETCH and SEND.
- **IDLE**
  - fifo_r_ena = enable & !fifo_empty, driven combinationally.
  - If fifo_r_ena is high, go to FETCH.
- **FETCH**
  - fifo_data is valid in this cycle.
  - Latch it into the shift register, clear the beat counter, go to SEND.
- **SEND**
  - out_valid = 1. out_data = top slice if MSB_FIRST, bottom slice otherwise.
  - out_last = (beat == NBEATS-1).
  - On out_valid & out_ready: shift by OUT_WIDTH and increment the beat counter.
  - On the accepted last beat: increment word_count. Then:
    - if enable & !fifo_empty: assert fifo_r_ena in the same cycle and go to FETCH;
    - otherwise go to IDLE.
- fifo_r_ena is 0 in FETCH, in SEND except on the accepted last beat, and whenever reset is high.
- Stream rule: once out_valid rises, out_data and out_last hold stable until accepted. out_valid is never retracted without a handshake.
- enable falling mid-word: the current word completes, then the FSM goes to IDLE. No further pops.
- fifo_empty during SEND has no effect until the last beat.
- Reset mid-word: the partial word is discarded. The FIFO is not re-read for it.
- Reset values: state IDLE, out_valid 0, out_data 0, out_last 0, busy 0, word_count 0, shift register 0, fifo_r_ena 0.

## Timing
- fifo_r_ena in cycle t → FETCH in t+1 → first out_valid in t+2.
- With out_ready held high:
  - a word occupies NBEATS SEND cycles;
  - back-to-back words leave exactly one bubble (the FETCH cycle) between the last beat and the next first beat;
  - sustained throughput is NBEATS/(NBEATS+1) beats per cycle.
- Backpressure adds one cycle per cycle of out_ready low. There is no combinational path from out_ready to out_valid.
- The combinational path from fifo_empty/enable/out_ready to fifo_r_ena is permitted: the FIFO samples it on the next edge.
- word_count updates on the edge that accepts the last beat.

## Structure
- Package fifo_serializer_pkg holds:
  - the state enum (IDLE=2'd0, FETCH=2'd1, SEND=2'd2);
  - the word_count width constant (16).
- Elaboration check: DATA_WIDTH % OUT_WIDTH == 0 and NBEATS >= 2; fail otherwise.
- Single module, no sub-module. Shift register, beat counter and FSM all live in fifo_byte_serializer.

## Test plan
- **Reset:** assert reset 3 cycles with fifo_empty=0 and enable=1 → fifo_r_ena 0 throughout. All outputs 0. State IDLE on release.
- **Single word:** fifo_data=0xA1B2C3D4, MSB_FIRST=1, out_ready=1.
  - fifo_r_ena pulses once.
  - Beats A1, B2, C3, D4 on consecutive cycles starting 2 cycles after the pulse.
  - out_last only on D4; word_count → 1.
  - Repeat with MSB_FIRST=0 → D4, C3, B2, A1.
- **Backpressure:** drop out_ready for 3 cycles while B2 is presented → out_data=B2 and out_valid=1 held stable. C3 follows the cycle after out_ready returns.
- **Back-to-back:** two words 0x11223344 and 0x55667788 with fifo_empty=0.
  - fifo_r_ena on the cycle 0x44 is accepted.
  - Exactly one idle cycle, then 0x55.
  - word_count → 2.
- **enable drop:** enable=0 after beat 1 → remaining 3 beats still sent, no further fifo_r_ena, FSM returns to IDLE, busy → 0.
- **Reset mid-word:** assert reset after beat 2 → out_valid 0 and word_count 0 next cycle. No fifo_r_ena until reset releases and fifo_empty=0.
